// File: rtl/sd_fifo_pkg.sv
// Shared definitions for the SD FIFO read streamer: FSM encoding, default
// block size and the counter width helper.
package sd_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam int BLK_BYTES_DEF = 512;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int byte_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_fifo_rd_streamer.sv
// Pops DATA_W-bit words from a FIFO and streams them MSB-byte-first as SD
// data blocks of BLK_BYTES bytes, flagging the last byte of every block.
module sd_fifo_rd_streamer
  import sd_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BLK_BYTES = BLK_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       blk_cnt,
  input  logic              abort,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int BPW = DATA_W / 8;
  localparam int BCW = byte_cnt_w(BLK_BYTES);
  localparam int WCW = byte_cnt_w(BPW);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLK_BYTES - 1);
  localparam logic [WCW-1:0] LAST_WB   = WCW'(BPW - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sreg_q,  sreg_d;
  logic [BCW-1:0]     bcnt_q,  bcnt_d;
  logic [WCW-1:0]     wcnt_q,  wcnt_d;
  logic [15:0]        blk_q,   blk_d;

  logic blk_end;
  logic xfer;

  assign blk_end = (bcnt_q == LAST_BYTE);
  // abort wins over the handshake: no byte is offered in an aborting cycle
  assign xfer    = (state_q == ST_SHIFT) && m_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    blk_d      = blk_q;
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    done       = 1'b0;
    m_data     = sreg_q[DATA_W-1 -: 8];
    busy       = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          blk_d   = blk_cnt;
          bcnt_d  = '0;
          wcnt_d  = '0;
          state_d = (blk_cnt != 16'd0) ? ST_FETCH : ST_FINISH;
        end
      end
      ST_FETCH: begin
        if (!fifo_rd_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sreg_d  = fifo_rd_data;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        m_valid = !abort;
        m_last  = blk_end && !abort;
        if (xfer) begin
          sreg_d = sreg_q << 8;
          bcnt_d = blk_end ? '0 : bcnt_q + BCW'(1);
          wcnt_d = (wcnt_q == LAST_WB) ? '0 : wcnt_q + WCW'(1);
          if (blk_end) blk_d = blk_q - 16'd1;
          // blocks are whole words, so a block always ends on a word boundary
          if (wcnt_q == LAST_WB)
            state_d = (blk_end && blk_q == 16'd1) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: begin
        done    = !abort;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // a word popped in an aborting FETCH cycle is simply never loaded
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sreg_d  = '0;
      bcnt_d  = '0;
      wcnt_d  = '0;
      blk_d   = '0;
    end
  end

endmodule

// File: tb/tb_sd_fifo_rd_streamer.sv
// Scoreboard bench for sd_fifo_rd_streamer with a behavioural FIFO whose
// word n carries bytes 4n..4n+3 (mod 256), MSB first.
module tb_sd_fifo_rd_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] blk_cnt = 16'd0;
  logic        abort = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = 32'd0;
  logic        fifo_rd_empty;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sd_fifo_rd_streamer #(.DATA_W(32), .BLK_BYTES(512)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .blk_cnt      (blk_cnt),
    .abort        (abort),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural FIFO: words below wr_ptr are available, data one cycle after pop
  logic [31:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_rd_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, bytes_rx = 0, last_cnt = 0, done_cnt = 0;
  int last_cyc = 0, done_cyc = 0, rden_cyc = 0, val_cyc = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected stream for a transfer starting at FIFO word first_w
  task automatic push_bytes(input int first_w, input int nbytes);
    exp_t e;
    for (int n = 0; n < nbytes; n++) begin
      e.d = 8'((4 * first_w + n) & 255);
      e.l = ((n % 512) == 511);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input int n, output int lat);
    @(negedge clk);
    start   = 1'b1;
    blk_cnt = 16'(n);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    forever begin
      #4;
      if (m_valid || lat >= 50) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done(input int d0, input int bound);
    for (int k = 0; k < bound && done_cnt == d0; k++) @(negedge clk);
    chk("done_seen", done_cnt - d0, 1);
  endtask

  // m_ready source
  initial begin
    forever begin
      @(negedge clk);
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples just before each rising edge
  initial begin
    exp_t e;
    logic       hold_pending;
    logic [7:0] held_d;
    logic       held_l;
    hold_pending = 1'b0;
    held_d = 8'd0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (fifo_rd_en) rden_cyc++;
        if (m_valid) val_cyc++;
        if (fifo_rd_en && fifo_rd_empty) chk("underrun_pop", 1, 0);
        if (hold_pending && m_valid) begin
          chk("hold_data", m_data, held_d);
          chk("hold_last", m_last, held_l);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_byte", {24'd0, m_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte", m_data, e.d);
            chk("last_flag", m_last, e.l);
          end
          bytes_rx++;
          if (m_last) begin
            last_cnt++;
            last_cyc = cyc;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        hold_pending = m_valid && !m_ready;
        held_d = m_data;
        held_l = m_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, l0, b0, r0, v0, k;
    for (int i = 0; i < 1024; i++)
      mem[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};

    // Reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // One block, ready always high
    wr_ptr = 128;
    push_bytes(0, 512);
    d0 = done_cnt; l0 = last_cnt; b0 = bytes_rx;
    start_xfer(1, lat);
    chk("t1_latency", lat, 3);
    wait_done(d0, 2000);
    chk("t1_bytes", bytes_rx - b0, 512);
    chk("t1_lasts", last_cnt - l0, 1);
    chk("t1_done_gap", done_cyc - last_cyc, 1);
    chk("t1_queue", exp_q.size(), 0);

    // Zero blocks
    d0 = done_cnt; r0 = rden_cyc; v0 = val_cyc;
    @(negedge clk);
    start = 1'b1;
    blk_cnt = 16'd0;
    #4;
    chk("t2_done_early", done, 0);
    @(negedge clk);
    start = 1'b0;
    #4;
    chk("t2_done_pulse", done, 1);
    chk("t2_busy_fin", busy, 1);
    @(negedge clk);
    #4;
    chk("t2_done_clear", done, 0);
    chk("t2_busy_idle", busy, 0);
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_no_rden", rden_cyc - r0, 0);
    chk("t2_no_valid", val_cyc - v0, 0);

    // FIFO runs dry mid-block for 20 cycles
    wr_ptr = 178;
    push_bytes(128, 512);
    d0 = done_cnt; l0 = last_cnt; b0 = bytes_rx;
    start_xfer(1, lat);
    chk("t3_latency", lat, 3);
    for (k = 0; k < 1000 && rd_ptr != wr_ptr; k++) @(negedge clk);
    chk("t3_drained", rd_ptr, 178);
    repeat (8) @(negedge clk);
    r0 = rden_cyc; v0 = val_cyc;
    repeat (20) @(negedge clk);
    chk("t3_stall_rden", rden_cyc - r0, 0);
    chk("t3_stall_valid", val_cyc - v0, 0);
    chk("t3_stall_busy", busy, 1);
    wr_ptr = 256;
    wait_done(d0, 2000);
    chk("t3_bytes", bytes_rx - b0, 512);
    chk("t3_lasts", last_cnt - l0, 1);
    chk("t3_queue", exp_q.size(), 0);

    // Three blocks with random back-pressure; a start while busy is ignored
    wr_ptr = 640;
    push_bytes(256, 1536);
    d0 = done_cnt; l0 = last_cnt; b0 = bytes_rx;
    rand_ready = 1'b1;
    start_xfer(3, lat);
    chk("t4_latency", lat, 3);
    repeat (30) @(negedge clk);
    start = 1'b1;
    blk_cnt = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, 10000);
    repeat (10) @(negedge clk);
    rand_ready = 1'b0;
    chk("t4_bytes", bytes_rx - b0, 1536);
    chk("t4_lasts", last_cnt - l0, 3);
    chk("t4_one_done", done_cnt - d0, 1);
    chk("t4_queue", exp_q.size(), 0);
    chk("t4_idle", busy, 0);

    // Abort while byte 100 of block 2 is on offer
    wr_ptr = 1024;
    push_bytes(640, 612);
    d0 = done_cnt; b0 = bytes_rx;
    start_xfer(3, lat);
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bytes_rx - b0 == 612 && m_valid) break;
    end
    chk("t5_reach", bytes_rx - b0, 612);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #4;
    chk("t5_busy", busy, 0);
    chk("t5_valid", m_valid, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_rd_ptr", rd_ptr, 794);
    chk("t5_queue", exp_q.size(), 0);

    push_bytes(794, 512);
    d0 = done_cnt; l0 = last_cnt; b0 = bytes_rx;
    start_xfer(1, lat);
    chk("t5b_latency", lat, 3);
    wait_done(d0, 2000);
    chk("t5b_bytes", bytes_rx - b0, 512);
    chk("t5b_lasts", last_cnt - l0, 1);
    chk("t5b_queue", exp_q.size(), 0);

    // Asynchronous reset in the middle of a block
    push_bytes(922, 20);
    d0 = done_cnt; b0 = bytes_rx;
    start_xfer(1, lat);
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bytes_rx - b0 == 20 && m_valid) break;
    end
    chk("t6_reach", bytes_rx - b0, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_last", m_last, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_rden", fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", m_valid, 0);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
